// File: rtl/iic_pkg.sv
// ============================================================================
// Module : iic_pkg
// Brief  : Shared types and constants for the I2C EEPROM arbiter and engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } iic_state_e;

    localparam logic       RW_WRITE        = 1'b0;
    localparam logic       RW_READ         = 1'b1;
    localparam logic [6:0] EEPROM_DEV_ADDR = 7'b1010000;

endpackage

`default_nettype wire

// File: rtl/iic_arbiter.sv
// ============================================================================
// Module : iic_arbiter
// Brief  : Round-robin two-client sequencer for the byte-level I2C EEPROM
//          engine, with a transfer timeout watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iic_arbiter
    import iic_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [7:0] rdata,
    output logic       eng_start,
    output logic       eng_rw,
    output logic [7:0] eng_addr,
    output logic [7:0] eng_wdata,
    output logic       eng_abort,
    input  logic       eng_busy,
    input  logic       eng_done,
    input  logic       eng_nack,
    input  logic [7:0] eng_rdata,
    output logic       busy
);

    localparam logic [15:0] C_CNT_LAST = TIMEOUT_CYC - 16'd1;

    iic_state_e  state_q, state_d;
    logic        cur_q, cur_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        w_win;
    logic        w_finish;

    // Under contention the client not served last wins; otherwise the sole requester.
    assign w_win = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err_d    = err_q;
        rdata_d  = rdata_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        w_finish = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = GRANT;
                    cur_d   = w_win;
                    gnt0_d  = ~w_win;
                    gnt1_d  = w_win;
                    rw_d    = w_win ? rw1    : rw0;
                    addr_d  = w_win ? addr1  : addr0;
                    wdata_d = w_win ? wdata1 : wdata0;
                end
            end
            GRANT: state_d = ISSUE;
            ISSUE: begin
                if (!eng_busy) begin
                    start_d = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eng_done) begin
                    // A NACKed read carries no valid byte, so it reports zero.
                    err_d    = eng_nack;
                    rdata_d  = (rw_q == RW_READ && !eng_nack) ? eng_rdata : 8'h00;
                    w_finish = 1'b1;
                end else if (cnt_q == C_CNT_LAST) begin
                    abort_d  = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = 8'h00;
                    w_finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                last_d  = cur_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (w_finish) begin
            state_d = RESP;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            done0_d = ~cur_q;
            done1_d = cur_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign eng_start = start_q;
    assign eng_abort = abort_q;
    assign eng_rw    = rw_q;
    assign eng_addr  = addr_q;
    assign eng_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_iic_arbiter.sv
// ============================================================================
// Module : tb_iic_arbiter
// Brief  : Directed self-checking bench for iic_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iic_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, rw0, rw1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err;
    logic [7:0] rdata;
    logic       eng_start, eng_rw, eng_abort, busy;
    logic [7:0] eng_addr, eng_wdata;
    logic       eng_busy, eng_done, eng_nack;
    logic [7:0] eng_rdata;

    int passes = 0;
    int total  = 0;

    iic_arbiter #(.TIMEOUT_CYC(16'd16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rdata(rdata),
        .eng_start(eng_start), .eng_rw(eng_rw), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_abort(eng_abort),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
        .eng_rdata(eng_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Starts from IDLE with requests already posted; ends back in IDLE.
    task automatic run_xact(input string tag, input logic cl,
                            input logic [7:0] e_addr, input logic [7:0] e_wdata,
                            input logic e_rw, input logic [7:0] erd,
                            input logic enack, input logic [7:0] e_rd);
        tick();
        chk({tag, ".gnt"}, {30'd0, gnt1, gnt0}, cl ? 32'd2 : 32'd1);
        chk({tag, ".fields"}, {15'd0, eng_rw, eng_addr, eng_wdata}, {15'd0, e_rw, e_addr, e_wdata});
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, ".nostart"}, {31'd0, eng_start}, 32'd0);
        tick();
        chk({tag, ".start"}, {31'd0, eng_start}, 32'd1);
        eng_done  = 1'b1;
        eng_rdata = erd;
        eng_nack  = enack;
        tick();
        eng_done  = 1'b0;
        chk({tag, ".done"}, {28'd0, done1, done0, gnt1, gnt0}, cl ? 32'h8 : 32'h4);
        chk({tag, ".result"}, {23'd0, eng_abort, err, rdata}, {23'd0, 1'b0, enack, e_rd});
        tick();
        chk({tag, ".idle"}, {29'd0, busy, done1, done0}, 32'd0);
    endtask

    initial begin
        logic early_abort;
        logic early_start;

        rst = 1'b1;
        {req0, req1, rw0, rw1} = 4'b0;
        {addr0, addr1, wdata0, wdata1} = 32'd0;
        {eng_busy, eng_done, eng_nack} = 3'b0;
        eng_rdata = 8'h00;
        tick();
        tick();
        chk("reset.ctl", {24'd0, gnt0, gnt1, done0, done1, err, eng_start, eng_abort, busy}, 32'd0);
        chk("reset.data", {8'd0, rdata, eng_addr, eng_wdata}, 32'd0);
        rst = 1'b0;
        tick();
        chk("reset.idle", {31'd0, busy}, 32'd0);

        // Contention: both held, service must alternate starting with client 0
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h11; wdata0 = 8'h5A;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h22; wdata1 = 8'h00;
        run_xact("cont0", 1'b0, 8'h11, 8'h5A, 1'b0, 8'hFF, 1'b0, 8'h00);
        run_xact("cont1", 1'b1, 8'h22, 8'h00, 1'b1, 8'h77, 1'b0, 8'h77);
        run_xact("cont2", 1'b0, 8'h11, 8'h5A, 1'b0, 8'h33, 1'b1, 8'h00);
        run_xact("cont3", 1'b1, 8'h22, 8'h00, 1'b1, 8'h99, 1'b0, 8'h99);
        req0 = 1'b0; req1 = 1'b0;

        // Single write then single read
        req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h10; wdata0 = 8'hA5;
        run_xact("write", 1'b0, 8'h10, 8'hA5, 1'b0, 8'hEE, 1'b0, 8'h00);
        req0 = 1'b0;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h00;
        run_xact("read", 1'b1, 8'h20, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h3C);
        req1 = 1'b0;

        // Busy hold: start withheld for 20 cycles, then issued right after release
        eng_busy = 1'b1;
        req1 = 1'b1; addr1 = 8'h44;
        tick();
        chk("bhold.gnt", {31'd0, gnt1}, 32'd1);
        early_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (eng_start) early_start = 1'b1;
        end
        chk("bhold.withheld", {31'd0, early_start}, 32'd0);
        eng_busy = 1'b0;
        tick();
        chk("bhold.start", {31'd0, eng_start}, 32'd1);
        eng_done = 1'b1; eng_rdata = 8'h81;
        tick();
        eng_done = 1'b0;
        chk("bhold.done", {23'd0, done1, err, rdata}, {23'd0, 1'b1, 1'b0, 8'h81});
        req1 = 1'b0;
        tick();

        // Timeout: no eng_done, abort 16 cycles after entering WAIT
        req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h55;
        tick();
        tick();
        tick();
        chk("tmo.start", {31'd0, eng_start}, 32'd1);
        early_abort = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (eng_abort || done0) early_abort = 1'b1;
        end
        chk("tmo.noearly", {31'd0, early_abort}, 32'd0);
        tick();
        chk("tmo.abort", {21'd0, eng_abort, done0, gnt0, err, rdata}, {21'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00});
        tick();
        chk("tmo.pulse", {30'd0, eng_abort, busy}, 32'd0);

        // eng_done on the limit cycle wins over the timeout
        tick();
        tick();
        tick();
        chk("lim.start", {31'd0, eng_start}, 32'd1);
        for (int i = 1; i < 16; i++) tick();
        eng_done = 1'b1; eng_nack = 1'b0; eng_rdata = 8'h6B;
        tick();
        eng_done = 1'b0;
        chk("lim.done", {21'd0, eng_abort, done0, gnt0, err, rdata}, {21'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B});
        tick();

        // Reset mid-WAIT, then a normal transaction
        rw0 = 1'b0; addr0 = 8'h66; wdata0 = 8'hC3;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("rstw.pre", {30'd0, gnt0, busy}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rstw.drop", {27'd0, gnt0, busy, eng_start, done0, eng_abort}, 32'd0);
        tick();
        chk("rstw.hold", {28'd0, done0, eng_abort, eng_start, gnt0}, 32'd0);
        rst = 1'b0;
        run_xact("post_rst", 1'b0, 8'h66, 8'hC3, 1'b0, 8'h12, 1'b0, 8'h00);
        req0 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
